uart_tx_arbiter: RTL and testbench

Round-robin arbiter that shares one `uart_tx` word-stream transmitter among `NUM_REQ` independent requesters. A frame is a burst of words terminated by `req_last`, and each frame can be prefixed with a header word identifying its source. The block sits between the requester logic and the `tx_valid`/`tx_data`/`tx_ready` port of `uart_top`, and it owns all sequencing of that port.

---
 rtl/uart_pkg.sv | 35 +++
 rtl/rr_select.sv | 27 ++
 rtl/uart_tx_arbiter.sv | 109 ++++++++++
 tb/tb_uart_tx_arbiter.sv | 327 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared types and helpers for the UART transmit-side arbiter.
// Holds the header magic, the arbiter state enum and the round-robin pick function.
package uart_pkg;

    localparam logic [7:0] HDR_MAGIC = 8'hA5;
    localparam int         RR_MAX    = 16;

    typedef enum logic [1:0] {
        IDLE,
        HDR,
        DATA
    } arb_state_t;

    // First set bit of req at or above ptr, wrapping at num; 0 when req is empty.
    function automatic logic [3:0] rr_pick(
        input logic [RR_MAX-1:0] req,
        input logic [3:0]        ptr,
        input int                num
    );
        logic [3:0] pick;
        logic       found;
        int         idx;
        pick  = '0;
        found = 1'b0;
        for (int i = 0; i < RR_MAX; i++) begin
            idx = (int'(ptr) + i) % num;
            if (!found && (i < num) && req[idx[3:0]]) begin
                pick  = idx[3:0];
                found = 1'b1;
            end
        end
        return pick;
    endfunction

endpackage

// File: rtl/rr_select.sv
// Combinational round-robin selector: rotates priority so that ptr is searched first.
module rr_select
    import uart_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = 2
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [ID_W-1:0]    ptr,
    output logic [ID_W-1:0]    pick,
    output logic               any
);

    logic [RR_MAX-1:0] req_ext;
    logic [3:0]        pick_full;

    // NOTE: every variable gets a default at the top of always_comb so no path can infer a latch.
    always_comb begin
        req_ext                = '0;
        req_ext[NUM_REQ-1:0]   = req;
        pick_full              = rr_pick(req_ext, 4'(ptr), NUM_REQ);
    end

    assign pick = ID_W'(pick_full);
    assign any  = |req;

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one uart_tx word stream among NUM_REQ requesters,
// with optional per-frame header word and a MAX_BURST starvation guard.
module uart_tx_arbiter
    import uart_pkg::*;
#(
    parameter  int NUM_REQ   = 4,
    parameter  int W_OUT     = 24,
    parameter  int HDR_EN    = 1,
    parameter  int MAX_BURST = 16,
    localparam int ID_W      = (NUM_REQ > 2) ? $clog2(NUM_REQ) : 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_REQ-1:0]       req_valid,
    input  logic [NUM_REQ*W_OUT-1:0] req_data,
    input  logic [NUM_REQ-1:0]       req_last,
    output logic [NUM_REQ-1:0]       req_ready,
    output logic                     m_valid,
    output logic [W_OUT-1:0]         m_data,
    input  logic                     m_ready,
    output logic [ID_W-1:0]          grant_id,
    output logic                     busy
);

    localparam int               BC_W      = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;
    localparam logic [BC_W-1:0]  LAST_BEAT = BC_W'(MAX_BURST - 1);
    localparam logic [ID_W-1:0]  LAST_ID   = ID_W'(NUM_REQ - 1);

    arb_state_t        state;
    logic [ID_W-1:0]   rr_ptr;
    logic [BC_W-1:0]   beat_cnt;
    logic [ID_W-1:0]   pick;
    logic              any_req;
    logic              g_valid;
    logic              g_last;
    logic [W_OUT-1:0]  g_data;

    rr_select #(
        .NUM_REQ(NUM_REQ),
        .ID_W   (ID_W)
    ) u_rr_select (
        .req (req_valid),
        .ptr (rr_ptr),
        .pick(pick),
        .any (any_req)
    );

    assign g_valid = req_valid[grant_id];
    assign g_last  = req_last[grant_id];
    assign g_data  = req_data[int'(grant_id)*W_OUT +: W_OUT];
    assign busy    = (state != IDLE);

    // Header comes purely from registers; DATA is a zero-latency pass-through of the grantee.
    always_comb begin
        m_valid   = 1'b0;
        m_data    = '0;
        req_ready = '0;
        case (state)
            HDR: begin
                m_valid                = 1'b1;
                m_data[W_OUT-1 -: 8]   = HDR_MAGIC;
                m_data[ID_W-1:0]       = grant_id;
            end
            DATA: begin
                m_valid             = g_valid;
                m_data              = g_data;
                req_ready[grant_id] = m_ready;
            end
            default: ;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            grant_id <= '0;
            rr_ptr   <= '0;
            beat_cnt <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (any_req) begin
                        grant_id <= pick;
                        beat_cnt <= '0;
                        state    <= (HDR_EN != 0) ? HDR : DATA;
                    end
                end
                HDR: begin
                    if (m_ready) state <= DATA;
                end
                DATA: begin
                    if (g_valid && m_ready) begin
                        // A forced release at MAX_BURST looks the same as a frame end here.
                        if (g_last || (beat_cnt == LAST_BEAT)) begin
                            state    <= IDLE;
                            grant_id <= '0;
                            rr_ptr   <= (grant_id == LAST_ID) ? '0 : grant_id + 1'b1;
                        end else begin
                            beat_cnt <= beat_cnt + 1'b1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Self-checking bench for uart_tx_arbiter: requester queues, a transaction-level
// arbitration model checked every cycle, and literal expectations per scenario.
module tb_uart_tx_arbiter;

    localparam int NUM_REQ   = 4;
    localparam int W_OUT     = 24;
    localparam int HDR_EN    = 1;
    localparam int MAX_BURST = 4;
    localparam int DEPTH     = 32;

    logic                     clk = 1'b0;
    logic                     rst = 1'b1;
    logic [NUM_REQ-1:0]       req_valid;
    logic [NUM_REQ*W_OUT-1:0] req_data;
    logic [NUM_REQ-1:0]       req_last;
    logic [NUM_REQ-1:0]       req_ready;
    logic                     m_valid;
    logic [W_OUT-1:0]         m_data;
    logic                     m_ready = 1'b1;
    logic [1:0]               grant_id;
    logic                     busy;

    uart_tx_arbiter #(
        .NUM_REQ  (NUM_REQ),
        .W_OUT    (W_OUT),
        .HDR_EN   (HDR_EN),
        .MAX_BURST(MAX_BURST)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .req_valid(req_valid),
        .req_data (req_data),
        .req_last (req_last),
        .req_ready(req_ready),
        .m_valid  (m_valid),
        .m_data   (m_data),
        .m_ready  (m_ready),
        .grant_id (grant_id),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    // Requester side: each requester presents the head of its own word queue.
    logic [W_OUT-1:0]   fw [NUM_REQ][DEPTH];
    logic               fl [NUM_REQ][DEPTH];
    int                 head [NUM_REQ];
    int                 tail [NUM_REQ];
    logic [NUM_REQ-1:0] stall    = '0;
    logic [NUM_REQ-1:0] pop_mask = '0;

    for (genvar i = 0; i < NUM_REQ; i++) begin : g_req
        assign req_valid[i]                 = (head[i] < tail[i]) && !stall[i];
        assign req_data[i*W_OUT +: W_OUT]   = fw[i][head[i] % DEPTH];
        assign req_last[i]                  = fl[i][head[i] % DEPTH];
    end

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // Model: when the link is free, pick round-robin among valid requesters and
    // queue the words that grant must carry (header, then up to MAX_BURST words).
    typedef struct {
        logic [W_OUT-1:0] data;
        bit               hdr;
    } exp_t;

    exp_t             expq[$];
    exp_t             f_cur;
    bit               mbusy  = 1'b0;
    int               mg     = 0;
    int               mptr   = 0;
    int               k_m;
    int               n_m;
    bit               held_v = 1'b0;
    logic [W_OUT-1:0] held;
    logic [W_OUT-1:0] xfer_log[$];
    int               grant_log[$];

    function automatic int model_pick(input logic [NUM_REQ-1:0] v, input int ptr);
        for (int k = 0; k < NUM_REQ; k++)
            if (v[(ptr + k) % NUM_REQ]) return (ptr + k) % NUM_REQ;
        return 0;
    endfunction

    always @(negedge clk) begin
        pop_mask = req_valid & req_ready;
        if (rst) begin
            mbusy  = 1'b0;
            mptr   = 0;
            held_v = 1'b0;
            expq.delete();
        end else if (!mbusy) begin
            check("idle_busy",      32'(busy),      32'd0);
            check("idle_m_valid",   32'(m_valid),   32'd0);
            check("idle_m_data",    32'(m_data),    32'd0);
            check("idle_grant_id",  32'(grant_id),  32'd0);
            check("idle_req_ready", 32'(req_ready), 32'd0);
            if (|req_valid) begin
                mg = model_pick(req_valid, mptr);
                if (HDR_EN != 0) expq.push_back('{data: {8'hA5, 16'(mg)}, hdr: 1'b1});
                k_m = head[mg];
                n_m = 0;
                while (n_m < MAX_BURST && k_m < tail[mg]) begin
                    expq.push_back('{data: fw[mg][k_m], hdr: 1'b0});
                    n_m++;
                    if (fl[mg][k_m]) break;
                    k_m++;
                end
                grant_log.push_back(mg);
                mbusy = 1'b1;
            end
        end else begin
            f_cur = expq[0];
            check("busy",      32'(busy),     32'd1);
            check("grant_id",  32'(grant_id), 32'(mg));
            check("m_valid",   32'(m_valid),  f_cur.hdr ? 32'd1 : 32'(req_valid[mg]));
            check("req_ready", 32'(req_ready), (!f_cur.hdr && m_ready) ? 32'(1 << mg) : 32'd0);
            if (held_v && m_valid) check("m_data_stable", 32'(m_data), 32'(held));
            held_v = m_valid && !m_ready;
            held   = m_data;
            if (m_valid && m_ready) begin
                check("m_data", 32'(m_data), 32'(f_cur.data));
                xfer_log.push_back(m_data);
                void'(expq.pop_front());
                if (expq.size() == 0) begin
                    mbusy  = 1'b0;
                    mptr   = (mg + 1) % NUM_REQ;
                    held_v = 1'b0;
                end
            end
        end
    end

    function automatic logic [31:0] xl(input int i);
        return (i < xfer_log.size()) ? 32'(xfer_log[i]) : 32'hxxxxxxxx;
    endfunction

    function automatic logic [31:0] gl(input int i);
        return (i < grant_log.size()) ? 32'(grant_log[i]) : 32'hxxxxxxxx;
    endfunction

    function automatic bit all_empty();
        for (int i = 0; i < NUM_REQ; i++) if (head[i] < tail[i]) return 1'b0;
        return 1'b1;
    endfunction

    // All stimulus changes happen 1 time unit after a rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
        for (int i = 0; i < NUM_REQ; i++) if (pop_mask[i]) head[i]++;
    endtask

    task automatic push(input int i, input logic [W_OUT-1:0] d, input logic l);
        fw[i][tail[i]] = d;
        fl[i][tail[i]] = l;
        tail[i]++;
    endtask

    task automatic clear_logs();
        xfer_log.delete();
        grant_log.delete();
    endtask

    task automatic wait_idle(input string name, input bit rnd);
        int cyc = 0;
        while ((!all_empty() || mbusy) && cyc < 400) begin
            tick();
            cyc++;
            if (rnd) m_ready = 1'($urandom_range(0, 1));
        end
        m_ready = 1'b1;
        check(name, 32'(cyc < 400), 32'd1);
        tick();
    endtask

    int exp_rr [9] = '{0, 1, 2, 3, 0, 1, 2, 3, 0};

    initial begin
        int cyc;
        for (int i = 0; i < NUM_REQ; i++) begin
            head[i] = 0;
            tail[i] = 0;
            for (int j = 0; j < DEPTH; j++) begin
                fw[i][j] = '0;
                fl[i][j] = 1'b0;
            end
        end
        repeat (3) tick();
        rst = 1'b0;
        tick();

        // Round-robin from reset, then a lone req0 frame moves the pointer to 1.
        clear_logs();
        for (int i = 0; i < NUM_REQ; i++) push(i, 24'hC00000 + 24'(i), 1'b1);
        wait_idle("rr_pass1_done", 1'b0);
        push(0, 24'hC10000, 1'b1);
        wait_idle("rr_single_done", 1'b0);
        for (int i = 0; i < NUM_REQ; i++) push(i, 24'hC20000 + 24'(i), 1'b1);
        wait_idle("rr_pass2_done", 1'b0);
        for (int i = 0; i < 9; i++) check("rr_order", gl(i), 32'(exp_rr[i]));

        // Single requester with header; busy drops right after the last beat.
        clear_logs();
        push(1, 24'h112233, 1'b0);
        push(1, 24'h445566, 1'b1);
        cyc = 0;
        while (xfer_log.size() < 3 && cyc < 200) begin
            tick();
            cyc++;
        end
        check("t1_wait_done", 32'(cyc < 200), 32'd1);
        check("t1_busy_fall", 32'(busy), 32'd0);
        check("t1_w0", xl(0), 32'hA50001);
        check("t1_w1", xl(1), 32'h112233);
        check("t1_w2", xl(2), 32'h445566);
        wait_idle("t1_done", 1'b0);

        // Backpressure: random m_ready through header and data.
        clear_logs();
        push(0, 24'hB00000, 1'b0);
        push(0, 24'hB00001, 1'b0);
        push(0, 24'hB00002, 1'b1);
        push(3, 24'hB30000, 1'b0);
        push(3, 24'hB30001, 1'b1);
        wait_idle("bp_done", 1'b1);
        check("bp_count", 32'(xfer_log.size()), 32'd7);
        check("bp_g0", gl(0), 32'd3);
        check("bp_g1", gl(1), 32'd0);
        check("bp_w1", xl(1), 32'hB30000);
        check("bp_w6", xl(6), 32'hB00002);

        // Forced release at MAX_BURST with req3 pending behind req2.
        clear_logs();
        for (int j = 0; j < 6; j++) push(2, 24'hD20000 + 24'(j), j == 5);
        cyc = 0;
        while (grant_log.size() < 1 && cyc < 50) begin
            tick();
            cyc++;
        end
        check("mb_grant_seen", 32'(cyc < 50), 32'd1);
        push(3, 24'hD30000, 1'b0);
        push(3, 24'hD30001, 1'b1);
        wait_idle("mb_done", 1'b0);
        check("mb_count", 32'(xfer_log.size()), 32'd11);
        check("mb_g0", gl(0), 32'd2);
        check("mb_g1", gl(1), 32'd3);
        check("mb_g2", gl(2), 32'd2);
        check("mb_w0", xl(0),  32'hA50002);
        check("mb_w4", xl(4),  32'hD20003);
        check("mb_w5", xl(5),  32'hA50003);
        check("mb_w8", xl(8),  32'hA50002);
        check("mb_w10", xl(10), 32'hD20005);

        // Granted requester stalls mid-frame while req1 waits.
        clear_logs();
        push(0, 24'hE00000, 1'b0);
        push(0, 24'hE00001, 1'b0);
        push(0, 24'hE00002, 1'b1);
        cyc = 0;
        while (head[0] < tail[0] - 2 && cyc < 50) begin
            tick();
            cyc++;
        end
        check("st_first_beat", 32'(cyc < 50), 32'd1);
        stall[0] = 1'b1;
        push(1, 24'hE10000, 1'b1);
        repeat (5) begin
            @(negedge clk);
            check("st_m_valid",   32'(m_valid),      32'd0);
            check("st_grant_id",  32'(grant_id),     32'd0);
            check("st_req1_wait", 32'(req_ready[1]), 32'd0);
            tick();
        end
        stall[0] = 1'b0;
        wait_idle("st_done", 1'b0);
        check("st_g0", gl(0), 32'd0);
        check("st_g1", gl(1), 32'd1);
        check("st_count", 32'(xfer_log.size()), 32'd6);

        // Reset in the middle of a DATA beat.
        push(2, 24'hF20000, 1'b0);
        push(2, 24'hF20001, 1'b0);
        push(2, 24'hF20002, 1'b1);
        cyc = 0;
        while (head[2] < tail[2] - 2 && cyc < 50) begin
            tick();
            cyc++;
        end
        check("rs_in_data", 32'(cyc < 50), 32'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) head[i] = tail[i];
        @(negedge clk);
        check("rs_m_valid",   32'(m_valid),   32'd0);
        check("rs_m_data",    32'(m_data),    32'd0);
        check("rs_req_ready", 32'(req_ready), 32'd0);
        check("rs_grant_id",  32'(grant_id),  32'd0);
        check("rs_busy",      32'(busy),      32'd0);
        tick();
        clear_logs();
        push(3, 24'hF30000, 1'b1);
        push(0, 24'hF00000, 1'b1);
        wait_idle("rs_done", 1'b0);
        check("rs_g0", gl(0), 32'd0);
        check("rs_g1", gl(1), 32'd3);
        check("rs_hdr", xl(0), 32'hA50000);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, checks %0d/%0d", n_pass, n_checks);
        $fatal(1);
    end

endmodule
